btb_sa_pred: RTL and testbench

- Parametrised set-associative branch target buffer with per-entry 2-bit direction counters.
- Sits beside the IF stage: combinational lookup on `pc_if` supplies predicted target, hit, and predicted direction.
- Clocked updates come from writeback with resolved branch outcome.
- Generalises the fixed 4-way/32-set target-only BTB:
  - configurable ways/sets/width,
  - tree pseudo-LRU for any power-of-two way count,
  - invalid-way-first allocation,
  - saturating direction counters,
  - flush and reset.

---
 rtl/btb_sa_pred.sv | 189 ++++++++++++++++++
 tb/tb_btb_sa_pred.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_sa_pred.sv
// Set-associative branch target buffer with 2-bit direction counters.
// Lookup on pc_if is purely combinational against pre-edge state.
// Writeback updates arrive on the rising clock edge.
// Victim choice is the lowest invalid way, otherwise the tree pseudo-LRU way.
module btb_sa_pred #(
    parameter int unsigned WAYS   = 4,
    parameter int unsigned SETS   = 32,
    parameter int unsigned ADDR_W = 16,
    localparam int unsigned IDX_W = $clog2(SETS),
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_if,
    output logic              pred_hit,
    output logic [ADDR_W-1:0] pred_target,
    output logic              pred_taken,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_taken,
    input  logic              upd_uncond,
    input  logic              flush
);

    localparam int unsigned LVL    = $clog2(WAYS);
    localparam int unsigned WAY_W  = (WAYS > 1) ? LVL : 1;
    localparam int unsigned PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

    typedef logic [WAY_W-1:0]  way_t;
    typedef logic [PLRU_W-1:0] plru_t;

    // Walk the heap-ordered tree from the root; a 0 bit means go left.
    function automatic way_t plru_victim(input plru_t bits);
        way_t        way;
        int unsigned node;
        plru_t       sh;
        way  = '0;
        node = 0;
        for (int unsigned l = 0; l < LVL; l++) begin
            sh   = bits >> node;
            way  = way_t'({way, sh[0]});
            node = 2 * node + (sh[0] ? 32'd2 : 32'd1);
        end
        return way;
    endfunction

    // Make every node on the path to 'way' point at the other subtree.
    function automatic plru_t plru_touch(input plru_t bits, input way_t way);
        plru_t       res;
        int unsigned node;
        way_t        sh;
        logic        b;
        res  = bits;
        node = 0;
        for (int unsigned l = 0; l < LVL; l++) begin
            sh   = way >> (LVL - 1 - l);
            b    = sh[0];
            res  = (res & ~(plru_t'(1) << node)) | (plru_t'(!b) << node);
            node = 2 * node + (b ? 32'd2 : 32'd1);
        end
        return res;
    endfunction

    // Storage
    logic              valid_q  [SETS][WAYS];
    logic [TAG_W-1:0]  tag_q    [SETS][WAYS];
    logic [ADDR_W-1:0] target_q [SETS][WAYS];
    logic [1:0]        ctr_q    [SETS][WAYS];
    plru_t             plru_q   [SETS];

    // Lookup side
    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    way_t             rd_way;

    assign rd_idx = pc_if[IDX_W:1];
    assign rd_tag = pc_if[ADDR_W-1:IDX_W+1];

    // Lowest-numbered matching way wins (descending loop, last write sticks).
    always_comb begin
        pred_hit = 1'b0;
        rd_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[rd_idx][w] && (tag_q[rd_idx][w] == rd_tag)) begin
                pred_hit = 1'b1;
                rd_way   = way_t'(w);
            end
        end
    end

    assign pred_target = pred_hit ? target_q[rd_idx][rd_way] : pc_if;
    assign pred_taken  = pred_hit & ctr_q[rd_idx][rd_way][1];

    // Update side
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic             upd_hit;
    way_t             hit_way;
    logic             has_inv;
    way_t             inv_way;
    way_t             victim;
    way_t             wr_way;
    logic             res_taken;
    logic [1:0]       cur_ctr;
    logic [1:0]       ctr_d;
    plru_t            plru_d;
    logic             do_write;

    assign wr_idx = upd_pc[IDX_W:1];
    assign wr_tag = upd_pc[ADDR_W-1:IDX_W+1];
    assign victim = plru_victim(plru_q[wr_idx]);

    // Tag match and lowest invalid way in the update set.
    always_comb begin
        upd_hit = 1'b0;
        hit_way = '0;
        has_inv = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[wr_idx][w] && (tag_q[wr_idx][w] == wr_tag)) begin
                upd_hit = 1'b1;
                hit_way = way_t'(w);
            end
            if (!valid_q[wr_idx][w]) begin
                has_inv = 1'b1;
                inv_way = way_t'(w);
            end
        end
    end

    // Next counter, PLRU bits and the write enable for the selected way.
    always_comb begin
        res_taken = upd_taken | upd_uncond;
        wr_way    = upd_hit ? hit_way : (has_inv ? inv_way : victim);
        cur_ctr   = ctr_q[wr_idx][hit_way];
        if (upd_hit) begin
            if (upd_uncond) begin
                ctr_d = 2'b11;
            end else if (res_taken) begin
                ctr_d = (cur_ctr == 2'b11) ? 2'b11 : cur_ctr + 2'd1;
            end else begin
                ctr_d = (cur_ctr == 2'b00) ? 2'b00 : cur_ctr - 2'd1;
            end
        end else begin
            ctr_d = upd_uncond ? 2'b11 : 2'b10;
        end
        plru_d   = plru_touch(plru_q[wr_idx], wr_way);
        // Not-taken misses never allocate.
        do_write = upd_valid & ~flush & (upd_hit | res_taken);
    end

    // Valid, counter and PLRU state with async reset; flush clears valid/PLRU only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                plru_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    ctr_q[s][w]   <= 2'b01;
                end
            end
        end else if (flush) begin
            for (int s = 0; s < SETS; s++) begin
                plru_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                end
            end
        end else if (do_write) begin
            valid_q[wr_idx][wr_way] <= 1'b1;
            ctr_q[wr_idx][wr_way]   <= ctr_d;
            plru_q[wr_idx]          <= plru_d;
        end
    end

    // Tag and target payload; meaningless while the valid bit is clear.
    always_ff @(posedge clk) begin
        if (do_write) begin
            tag_q[wr_idx][wr_way]    <= wr_tag;
            target_q[wr_idx][wr_way] <= upd_target;
        end
    end

    // PC bit 0 is ignored: instructions are word aligned.
    logic unused_pc_lsb;
    assign unused_pc_lsb = pc_if[0] ^ upd_pc[0];

endmodule

// File: tb/tb_btb_sa_pred.sv
// Scoreboard bench for btb_sa_pred: a 4-way/32-set instance and a 1-way/4-set instance.
module tb_btb_sa_pred;

    logic clk;
    logic rst_n;

    logic [15:0] pc_a, upd_pc_a, upd_target_a, pred_target_a;
    logic        hit_a, taken_a, upd_valid_a, upd_taken_a, upd_uncond_a, flush_a;
    logic [15:0] pc_b, upd_pc_b, upd_target_b, pred_target_b;
    logic        hit_b, taken_b, upd_valid_b, upd_taken_b, upd_uncond_b, flush_b;

    btb_sa_pred #(.WAYS(4), .SETS(32), .ADDR_W(16)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_if      (pc_a),
        .pred_hit   (hit_a),
        .pred_target(pred_target_a),
        .pred_taken (taken_a),
        .upd_valid  (upd_valid_a),
        .upd_pc     (upd_pc_a),
        .upd_target (upd_target_a),
        .upd_taken  (upd_taken_a),
        .upd_uncond (upd_uncond_a),
        .flush      (flush_a)
    );

    btb_sa_pred #(.WAYS(1), .SETS(4), .ADDR_W(16)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_if      (pc_b),
        .pred_hit   (hit_b),
        .pred_target(pred_target_b),
        .pred_taken (taken_b),
        .upd_valid  (upd_valid_b),
        .upd_pc     (upd_pc_b),
        .upd_target (upd_target_b),
        .upd_taken  (upd_taken_b),
        .upd_uncond (upd_uncond_b),
        .flush      (flush_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind 0/1: lookup on dut_a/dut_b; kind 2/3: counter backdoor on dut_a/dut_b
    typedef struct {
        int          kind;
        string       name;
        logic [15:0] target;
        logic        hit;
        logic        taken;
        int          set;
        int          way;
        logic [1:0]  ctr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    exp_t        mon_e;
    logic        act_hit, act_taken;
    logic [15:0] act_tgt;
    logic [1:0]  act_ctr;

    // Monitor: drains all expectations issued during this cycle, away from the rising edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            if (mon_e.kind == 0 || mon_e.kind == 1) begin
                act_hit   = (mon_e.kind == 0) ? hit_a : hit_b;
                act_taken = (mon_e.kind == 0) ? taken_a : taken_b;
                act_tgt   = (mon_e.kind == 0) ? pred_target_a : pred_target_b;
                checks += 3;
                if (act_hit !== mon_e.hit) begin
                    errors++;
                    $display("FAIL %s hit: got %b want %b", mon_e.name, act_hit, mon_e.hit);
                end
                if (act_taken !== mon_e.taken) begin
                    errors++;
                    $display("FAIL %s taken: got %b want %b", mon_e.name, act_taken,
                             mon_e.taken);
                end
                if (act_tgt !== mon_e.target) begin
                    errors++;
                    $display("FAIL %s target: got %h want %h", mon_e.name, act_tgt,
                             mon_e.target);
                end
            end else begin
                if (mon_e.kind == 2) act_ctr = dut_a.ctr_q[mon_e.set][mon_e.way];
                else                 act_ctr = dut_b.ctr_q[mon_e.set][mon_e.way];
                checks++;
                if (act_ctr !== mon_e.ctr) begin
                    errors++;
                    $display("FAIL %s ctr[%0d][%0d]: got %b want %b", mon_e.name, mon_e.set,
                             mon_e.way, act_ctr, mon_e.ctr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input int kind, input logic [15:0] pc, input logic hit,
                        input logic tk, input logic [15:0] tgt, input string nm);
        exp_t e;
        if (kind == 0) pc_a = pc;
        else           pc_b = pc;
        e.kind = kind; e.name = nm; e.hit = hit; e.taken = tk; e.target = tgt;
        e.set = 0; e.way = 0; e.ctr = 2'b00;
        sb.push_back(e);
        tick();
    endtask

    task automatic miss(input int kind, input logic [15:0] pc, input string nm);
        look(kind, pc, 1'b0, 1'b0, pc, nm);
    endtask

    task automatic chk_ctr(input int kind, input int set, input int way, input logic [1:0] c,
                           input string nm);
        exp_t e;
        e.kind = kind; e.name = nm; e.hit = 1'b0; e.taken = 1'b0; e.target = '0;
        e.set = set; e.way = way; e.ctr = c;
        sb.push_back(e);
    endtask

    task automatic upd_a(input logic [15:0] pc, input logic [15:0] tgt, input logic tk,
                         input logic un);
        upd_valid_a = 1'b1; upd_pc_a = pc; upd_target_a = tgt;
        upd_taken_a = tk; upd_uncond_a = un;
        tick();
        upd_valid_a = 1'b0;
    endtask

    task automatic upd_b(input logic [15:0] pc, input logic [15:0] tgt, input logic tk,
                         input logic un);
        upd_valid_b = 1'b1; upd_pc_b = pc; upd_target_b = tgt;
        upd_taken_b = tk; upd_uncond_b = un;
        tick();
        upd_valid_b = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        pc_a = 16'h3000; upd_valid_a = 0; upd_pc_a = 0; upd_target_a = 0;
        upd_taken_a = 0; upd_uncond_a = 0; flush_a = 0;
        pc_b = 16'h0000; upd_valid_b = 0; upd_pc_b = 0; upd_target_b = 0;
        upd_taken_b = 0; upd_uncond_b = 0; flush_b = 0;
        #2 rst_n = 1'b0;
        tick();
        tick();

        // Reset state
        chk_ctr(2, 0, 0, 2'b01, "rst_ctr_s0");
        chk_ctr(2, 2, 3, 2'b01, "rst_ctr_s2w3");
        miss(0, 16'h3000, "rst_lookup");
        rst_n = 1'b1;
        tick();

        // Allocate a conditional taken branch, then walk its counter down
        upd_a(16'h3004, 16'h3100, 1'b1, 1'b0);
        look(0, 16'h3004, 1'b1, 1'b1, 16'h3100, "alloc_hit");
        chk_ctr(2, 2, 0, 2'b10, "alloc_ctr");
        upd_a(16'h3004, 16'h3100, 1'b0, 1'b0);
        look(0, 16'h3004, 1'b1, 1'b0, 16'h3100, "nt1");
        chk_ctr(2, 2, 0, 2'b01, "nt1_ctr");
        upd_a(16'h3004, 16'h3100, 1'b0, 1'b0);
        upd_a(16'h3004, 16'h3100, 1'b0, 1'b0);
        chk_ctr(2, 2, 0, 2'b00, "nt3_ctr");
        upd_a(16'h3004, 16'h3106, 1'b0, 1'b0);
        look(0, 16'h3004, 1'b1, 1'b0, 16'h3106, "nt4_retarget");
        chk_ctr(2, 2, 0, 2'b00, "nt4_floor");

        // Not-taken miss never allocates
        upd_a(16'h3008, 16'h3200, 1'b0, 1'b0);
        miss(0, 16'h3008, "nt_miss");
        chk_ctr(2, 4, 0, 2'b01, "nt_miss_ctr");

        // Fill set 1, fifth allocation evicts way 0
        upd_a(16'h3002, 16'h4002, 1'b1, 1'b0);
        upd_a(16'h3042, 16'h4042, 1'b1, 1'b0);
        upd_a(16'h3082, 16'h4082, 1'b1, 1'b0);
        upd_a(16'h30C2, 16'h40C2, 1'b1, 1'b0);
        look(0, 16'h3002, 1'b1, 1'b1, 16'h4002, "fill_w0");
        look(0, 16'h30C2, 1'b1, 1'b1, 16'h40C2, "fill_w3");
        upd_a(16'h3102, 16'h4102, 1'b1, 1'b0);
        miss(0, 16'h3002, "evict_w0");
        look(0, 16'h3042, 1'b1, 1'b1, 16'h4042, "keep_3042");
        look(0, 16'h3082, 1'b1, 1'b1, 16'h4082, "keep_3082");
        look(0, 16'h30C2, 1'b1, 1'b1, 16'h40C2, "keep_30c2");
        look(0, 16'h3102, 1'b1, 1'b1, 16'h4102, "new_3102");
        chk_ctr(2, 1, 0, 2'b10, "evict_ctr");

        // Fill set 3, re-touch way 1, then an unconditional allocation evicts way 2
        upd_a(16'h3006, 16'h5006, 1'b1, 1'b0);
        upd_a(16'h3046, 16'h5046, 1'b1, 1'b0);
        upd_a(16'h3086, 16'h5086, 1'b1, 1'b0);
        upd_a(16'h30C6, 16'h50C6, 1'b1, 1'b0);
        upd_a(16'h3046, 16'h5046, 1'b1, 1'b0);
        chk_ctr(2, 3, 1, 2'b11, "retouch_ctr");
        upd_a(16'h3106, 16'h5106, 1'b0, 1'b1);
        miss(0, 16'h3086, "evict_w2");
        look(0, 16'h3006, 1'b1, 1'b1, 16'h5006, "keep_3006");
        look(0, 16'h3046, 1'b1, 1'b1, 16'h5046, "keep_3046");
        look(0, 16'h30C6, 1'b1, 1'b1, 16'h50C6, "keep_30c6");
        look(0, 16'h3106, 1'b1, 1'b1, 16'h5106, "new_3106");
        chk_ctr(2, 3, 2, 2'b11, "jmp_alloc_ctr");

        // Flush wins over a same-cycle update; counters survive
        flush_a = 1'b1;
        upd_a(16'h300A, 16'h5555, 1'b1, 1'b0);
        flush_a = 1'b0;
        miss(0, 16'h3004, "flush_3004");
        miss(0, 16'h3042, "flush_3042");
        miss(0, 16'h300A, "flush_dropped");
        chk_ctr(2, 2, 0, 2'b00, "flush_keeps_ctr");
        chk_ctr(2, 5, 0, 2'b01, "flush_upd_ctr");
        upd_a(16'h3004, 16'h3300, 1'b1, 1'b0);
        look(0, 16'h3004, 1'b1, 1'b1, 16'h3300, "post_flush_alloc");

        // Async reset in the middle of an update cycle
        pc_a = 16'h3004;
        upd_valid_a = 1'b1; upd_pc_a = 16'h3004; upd_target_a = 16'h3400;
        upd_taken_a = 1'b1; upd_uncond_a = 1'b0;
        #2 rst_n = 1'b0;
        begin
            exp_t e;
            e.kind = 0; e.name = "async_rst"; e.hit = 1'b0; e.taken = 1'b0;
            e.target = 16'h3004; e.set = 0; e.way = 0; e.ctr = 2'b00;
            sb.push_back(e);
        end
        tick();
        upd_valid_a = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        miss(0, 16'h3004, "post_rst_3004");
        chk_ctr(2, 2, 0, 2'b01, "post_rst_ctr");

        // Single-way instance: replacement and JMP counter
        miss(1, 16'h0102, "b_empty");
        upd_b(16'h0102, 16'h0A00, 1'b1, 1'b0);
        look(1, 16'h0102, 1'b1, 1'b1, 16'h0A00, "b_alloc");
        chk_ctr(3, 1, 0, 2'b10, "b_alloc_ctr");
        upd_b(16'h0202, 16'h0B00, 1'b1, 1'b0);
        miss(1, 16'h0102, "b_replaced");
        look(1, 16'h0202, 1'b1, 1'b1, 16'h0B00, "b_new");
        upd_b(16'h0302, 16'h0C00, 1'b0, 1'b1);
        miss(1, 16'h0202, "b_replaced2");
        look(1, 16'h0302, 1'b1, 1'b1, 16'h0C00, "b_jmp");
        chk_ctr(3, 1, 0, 2'b11, "b_jmp_ctr");

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
